// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the toggle request/acknowledge CDC handshake pair.
package cdc_hs_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } rx_state_e;

  localparam int unsigned WIDTH_D_DEF     = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous active-high reset to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/receive_control.sv
// Receive side of the toggle CDC handshake: synchronise a_req, capture adin,
// present it with valid/ready and toggle b_ack when the consumer accepts.
module receive_control
  import cdc_hs_pkg::*;
#(
  parameter int unsigned WIDTH_D     = WIDTH_D_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               bclk,
  input  logic               brst,
  input  logic               a_req,
  input  logic [WIDTH_D-1:0] adin,
  input  logic               bready,
  output logic [WIDTH_D-1:0] bdata,
  output logic               bvalid,
  output logic               b_ack,
  output logic               b_err
);

  rx_state_e          state_q, state_d;
  logic               req_s;
  logic               req_last;
  logic               req_edge;
  logic               edge_q;
  logic [WIDTH_D-1:0] bdata_d;
  logic               bvalid_d;
  logic               b_ack_d;
  logic               b_err_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(bclk),
    .rst(brst),
    .d  (a_req),
    .q  (req_s)
  );

  assign req_edge = req_s ^ req_last;

  // The edge is registered before the FSM sees it, so capture happens one
  // cycle after req_last catches up: SYNC_STAGES + 1 edges after first sample.
  always_ff @(posedge bclk) begin
    if (brst) begin
      req_last <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      req_last <= req_s;
      edge_q   <= req_edge;
    end
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      state_q <= IDLE;
      bdata   <= '0;
      bvalid  <= 1'b0;
      b_ack   <= 1'b0;
      b_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      bdata   <= bdata_d;
      bvalid  <= bvalid_d;
      b_ack   <= b_ack_d;
      b_err   <= b_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bdata_d  = bdata;
    bvalid_d = bvalid;
    b_ack_d  = b_ack;
    b_err_d  = b_err;
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          bdata_d  = adin;
          bvalid_d = 1'b1;
          state_d  = VALID;
        end
      end
      VALID: begin
        // A new request while a word is still pending is dropped unacknowledged.
        if (edge_q) begin
          b_err_d = 1'b1;
        end
        if (bready) begin
          bvalid_d = 1'b0;
          b_ack_d  = ~b_ack;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_receive_control.sv
// Bench for receive_control: directed cases plus a behavioural sender on an unrelated clock.
module tb_receive_control;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         bclk   = 1'b0;
  logic         aclk   = 1'b0;
  logic         brst   = 1'b1;
  logic         a_req  = 1'b0;
  logic         bready = 1'b0;
  logic [W-1:0] adin   = '0;
  logic [W-1:0] bdata;
  logic         bvalid;
  logic         b_ack;
  logic         b_err;

  int checks = 0;
  int errors = 0;

  // Time units scaled so that aclk:bclk = 10:17 and bclk edges never coincide with stimulus.
  always #85 bclk = ~bclk;
  always #50 aclk = ~aclk;

  receive_control #(
    .WIDTH_D    (W),
    .SYNC_STAGES(S)
  ) dut (
    .bclk  (bclk),
    .brst  (brst),
    .a_req (a_req),
    .adin  (adin),
    .bready(bready),
    .bdata (bdata),
    .bvalid(bvalid),
    .b_ack (b_ack),
    .b_err (b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request toggle first sampled at edge N is acted on at edge N+S+1.
  bit           m_on = 1'b0;
  bit           hist[$];
  logic [W-1:0] m_data  = '0;
  bit           m_valid = 1'b0;
  bit           m_ack   = 1'b0;
  bit           m_err   = 1'b0;
  bit           sb_en   = 1'b0;
  logic [W-1:0] sent[$];
  int           rcvd = 0;

  function automatic bit past(input int unsigned d);
    if (hist.size() > d) return hist[hist.size()-1-d];
    return 1'b0;
  endfunction

  always @(posedge bclk) begin
    bit ev;
    logic [W-1:0] exp_w;
    if (brst) begin
      m_on    = 1'b1;
      hist.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
    end else if (m_on) begin
      hist.push_back(a_req);
      if (hist.size() > 8) void'(hist.pop_front());
      ev = past(S + 1) != past(S + 2);
      if (sb_en && bvalid === 1'b1 && bready) begin
        if (sent.size() == 0) begin
          chk("sb_unexpected_word", 32'(bdata), 32'hFFFF_FFFF);
        end else begin
          exp_w = sent.pop_front();
          chk("sb_word_order", 32'(bdata), 32'(exp_w));
        end
        rcvd++;
      end
      if (m_valid) begin
        if (ev) m_err = 1'b1;
        if (bready) begin
          m_valid = 1'b0;
          m_ack   = ~m_ack;
        end
      end else if (ev) begin
        m_data  = adin;
        m_valid = 1'b1;
      end
    end
    if (m_on) begin
      #1;
      chk("model_bvalid", 32'(bvalid), 32'(m_valid));
      chk("model_bdata",  32'(bdata),  32'(m_data));
      chk("model_b_ack",  32'(b_ack),  32'(m_ack));
      chk("model_b_err",  32'(b_err),  32'(m_err));
    end
  end

  // System requirement: a_req must be 0 when brst is released.
  logic brst_q = 1'b1;
  always @(posedge bclk) begin
    if (brst_q && !brst) begin
      checks++;
      assert (a_req == 1'b0)
      else begin
        errors++;
        $error("FAIL reset_release_a_req: got %0b required 0", a_req);
      end
    end
    brst_q <= brst;
  end

  // Sender-side synchroniser for b_ack.
  logic ack_s1 = 1'b0;
  logic ack_s2 = 1'b0;
  always @(posedge aclk) begin
    ack_s1 <= b_ack;
    ack_s2 <= ack_s1;
  end

  bit rnd_en = 1'b0;
  initial forever begin
    @(posedge bclk);
    #2;
    if (rnd_en) bready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic wait_valid();
    int unsigned t = 0;
    while (bvalid !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("wait_bvalid", 32'(bvalid), 32'd1);
  endtask

  task automatic send_words(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic [W-1:0] w;
      int unsigned t;
      w = W'($urandom);
      t = 0;
      @(posedge aclk);
      #1;
      adin  = w;
      a_req = ~a_req;
      sent.push_back(w);
      while (ack_s2 != a_req && t < 1000) begin
        @(posedge aclk);
        #1;
        t++;
      end
      chk("sender_ack_return", 32'(ack_s2), 32'(a_req));
      if (ack_s2 != a_req) return;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    repeat (3) tick();
    brst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_bvalid", 32'(bvalid), 32'd0);
      chk("idle_b_ack",  32'(b_ack),  32'd0);
      chk("idle_b_err",  32'(b_err),  32'd0);
    end

    // First word, consumer ready: capture three edges after first sample
    adin   = 8'hA5;
    a_req  = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_bvalid_low", 32'(bvalid), 32'd0);
    end
    tick();
    chk("a5_bvalid", 32'(bvalid), 32'd1);
    chk("a5_bdata",  32'(bdata),  32'hA5);
    chk("a5_b_ack_before", 32'(b_ack), 32'd0);
    tick();
    chk("a5_bvalid_fall", 32'(bvalid), 32'd0);
    chk("a5_b_ack",       32'(b_ack),  32'd1);

    // Backpressure
    adin   = 8'h3C;
    a_req  = 1'b0;
    bready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_bdata",  32'(bdata),  32'h3C);
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_b_ack",  32'(b_ack),  32'd1);
    end
    bready = 1'b1;
    tick();
    chk("bp_accept_bvalid", 32'(bvalid), 32'd0);
    chk("bp_accept_b_ack",  32'(b_ack),  32'd0);
    bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_single_toggle", 32'(b_ack), 32'd0);
    end

    // Protocol violation: second toggle while a word is pending
    adin  = 8'h11;
    a_req = 1'b1;
    wait_valid();
    chk("viol_first_word", 32'(bdata), 32'h11);
    adin  = 8'hFF;
    a_req = 1'b0;
    repeat (6) tick();
    chk("viol_b_err",  32'(b_err),  32'd1);
    chk("viol_bdata",  32'(bdata),  32'h11);
    chk("viol_bvalid", 32'(bvalid), 32'd1);
    chk("viol_b_ack",  32'(b_ack),  32'd0);
    bready = 1'b1;
    tick();
    chk("viol_accept_b_ack",  32'(b_ack),  32'd1);
    chk("viol_accept_bvalid", 32'(bvalid), 32'd0);
    bready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("viol_one_ack",   32'(b_ack),  32'd1);
      chk("viol_no_recap",  32'(bvalid), 32'd0);
      chk("viol_err_stick", 32'(b_err),  32'd1);
    end

    // Reset while a word is pending
    adin  = 8'h22;
    a_req = 1'b1;
    wait_valid();
    brst  = 1'b1;
    a_req = 1'b0;
    tick();
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bdata",  32'(bdata),  32'd0);
    chk("rst_b_ack",  32'(b_ack),  32'd0);
    chk("rst_b_err",  32'(b_err),  32'd0);
    tick();
    brst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
    end

    // Random traffic from a behavioural sender on aclk
    brst = 1'b1;
    repeat (2) tick();
    brst = 1'b0;
    repeat (3) tick();
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    repeat (4) @(posedge aclk);
    send_words(200);
    t = 0;
    while (rcvd < 200 && t < 100) begin
      tick();
      t++;
    end
    rnd_en = 1'b0;
    repeat (2) tick();
    chk("rand_received", 32'(rcvd), 32'd200);
    chk("rand_leftover", 32'(sent.size()), 32'd0);
    chk("rand_b_err",    32'(b_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
